// File: rtl/cmos_pkg.sv
// Shared types and constants for the DVP camera capture front end.
package cmos_pkg;

    localparam int H_PIXELS_DEF    = 640;
    localparam int V_LINES_DEF     = 480;
    localparam int SKIP_FRAMES_DEF = 10;

    typedef enum logic [1:0] {
        S_SKIP = 2'd0,
        S_WAIT = 2'd1,
        S_CAP  = 2'd2
    } cap_state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [4:0] rgb565_r(input logic [15:0] px);
        return px[15:11];
    endfunction

    function automatic logic [5:0] rgb565_g(input logic [15:0] px);
        return px[10:5];
    endfunction

    function automatic logic [4:0] rgb565_b(input logic [15:0] px);
        return px[4:0];
    endfunction

endpackage

// File: rtl/cmos_byte_pack.sv
// Pairs consecutive camera bytes into 16-bit words; the first byte of a pair is the high byte.
module cmos_byte_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic        phase_o,
    output logic [15:0] word_o,
    output logic        word_vld_o
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clr_i) begin
            phase_d = 1'b0;
        end else if (en_i) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = data_i;
            end
        end
    end

    assign phase_o    = phase_q;
    assign word_o     = {hi_q, data_i};
    assign word_vld_o = en_i & phase_q & ~clr_i;

endmodule

// File: rtl/cmos_capture.sv
// DVP camera capture: skips settling frames, packs RGB565 pixels and enforces frame geometry.
module cmos_capture
    import cmos_pkg::*;
#(
    parameter int H_PIXELS    = H_PIXELS_DEF,
    parameter int V_LINES     = V_LINES_DEF,
    parameter int SKIP_FRAMES = SKIP_FRAMES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    input  logic        cap_en,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    output logic        frame_err
);

    localparam int CW  = cnt_width(H_PIXELS);
    localparam int RW  = cnt_width(V_LINES);
    localparam int SKW = cnt_width(SKIP_FRAMES);
    localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    logic        vsync_q, vsync_dly_q, href_q, href_dly_q;
    logic [7:0]  data_q;
    cap_state_e  state_q, state_d;
    logic [SKW-1:0] skip_cnt_q, skip_cnt_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic        done_q, done_d;
    logic        line_err_q, line_err_d;
    logic        excess_q, excess_d;
    logic [15:0] dout_q, dout_d;
    logic        vld_q, vld_d, sop_q, sop_d, eop_q, eop_d, err_q, err_d;

    logic        vs_rise, href_fall, frame_full;
    logic        pack_clr, pack_en, pack_phase, word_vld;
    logic [15:0] word;

    // vsync history resets high so a vsync already asserted at reset is not a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q     <= 1'b1;
            vsync_dly_q <= 1'b1;
            href_q      <= 1'b0;
            href_dly_q  <= 1'b0;
            data_q      <= '0;
        end else begin
            vsync_q     <= cmos_vsync;
            vsync_dly_q <= vsync_q;
            href_q      <= cmos_href;
            href_dly_q  <= href_q;
            data_q      <= cmos_data;
        end
    end

    assign vs_rise    = vsync_q & ~vsync_dly_q;
    assign href_fall  = href_dly_q & ~href_q;
    assign frame_full = done_q | (row_q >= RW'(V_LINES));
    assign pack_clr   = (state_q != S_CAP) | vs_rise | href_fall;
    assign pack_en    = (state_q == S_CAP) & href_q & ~vs_rise;

    cmos_byte_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (pack_clr),
        .en_i       (pack_en),
        .data_i     (data_q),
        .phase_o    (pack_phase),
        .word_o     (word),
        .word_vld_o (word_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_SKIP;
            skip_cnt_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            done_q     <= 1'b0;
            line_err_q <= 1'b0;
            excess_q   <= 1'b0;
            dout_q     <= '0;
            vld_q      <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            done_q     <= done_d;
            line_err_q <= line_err_d;
            excess_q   <= excess_d;
            dout_q     <= dout_d;
            vld_q      <= vld_d;
            sop_q      <= sop_d;
            eop_q      <= eop_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        row_d      = row_q;
        col_d      = col_q;
        done_d     = done_q;
        line_err_d = line_err_q;
        excess_d   = excess_q;
        dout_d     = dout_q;
        vld_d      = 1'b0;
        sop_d      = 1'b0;
        eop_d      = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_SKIP: begin
                if (SKIP_FRAMES == 0) begin
                    state_d = S_WAIT;
                end else if (vs_rise) begin
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d    = S_WAIT;
                        skip_cnt_d = '0;
                    end else begin
                        skip_cnt_d = skip_cnt_q + SKW'(1);
                    end
                end
            end

            S_WAIT: begin
                row_d      = '0;
                col_d      = '0;
                done_d     = 1'b0;
                line_err_d = 1'b0;
                excess_d   = 1'b0;
                if (vs_rise && cap_en) begin
                    state_d = S_CAP;
                end
            end

            S_CAP: begin
                if (vs_rise) begin
                    // A frame boundary without a preceding eop means the frame came up short.
                    err_d      = ~done_q;
                    row_d      = '0;
                    col_d      = '0;
                    done_d     = 1'b0;
                    line_err_d = 1'b0;
                    excess_d   = 1'b0;
                    if (!cap_en) begin
                        state_d = S_WAIT;
                    end
                end else begin
                    if (word_vld && !frame_full) begin
                        if (col_q < CW'(H_PIXELS)) begin
                            dout_d = word;
                            vld_d  = 1'b1;
                            sop_d  = (row_q == '0) && (col_q == '0);
                            eop_d  = (row_q == RW'(V_LINES - 1)) && (col_q == CW'(H_PIXELS - 1));
                            col_d  = col_q + CW'(1);
                            done_d = eop_d;
                        end else if (!line_err_q) begin
                            err_d      = 1'b1;
                            line_err_d = 1'b1;
                        end
                    end
                    if (href_q && frame_full && !excess_q) begin
                        err_d    = 1'b1;
                        excess_d = 1'b1;
                    end
                    if (href_fall) begin
                        // Odd trailing byte: a high byte was latched with no partner.
                        if (pack_phase && !frame_full && !line_err_q) begin
                            err_d = 1'b1;
                        end
                        line_err_d = 1'b0;
                        if (col_q != '0) begin
                            row_d = row_q + RW'(1);
                            col_d = '0;
                        end
                    end
                end
            end

            default: state_d = S_SKIP;
        endcase
    end

    assign dout      = dout_q;
    assign dout_vld  = vld_q;
    assign dout_sop  = sop_q;
    assign dout_eop  = eop_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_cmos_capture.sv
// Directed bench for cmos_capture on a 4x2 frame with two skipped frames; scoreboard checks every pixel.
module tb_cmos_capture;
    import cmos_pkg::*;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int SKIP = 2;

    logic        clk = 1'b0;
    logic        rst, cmos_vsync, cmos_href, cap_en;
    logic [7:0]  cmos_data;
    logic [15:0] dout;
    logic        dout_vld, dout_sop, dout_eop, frame_err;

    typedef struct {
        logic [15:0] word;
        logic        sop;
        logic        eop;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          vld_cnt = 0, sop_cnt = 0, eop_cnt = 0, err_cnt = 0;
    int          vld_snap = 0, sop_snap = 0, eop_snap = 0, err_snap = 0;
    logic [15:0] sop_word = '0;

    cmos_capture #(
        .H_PIXELS    (H),
        .V_LINES     (V),
        .SKIP_FRAMES (SKIP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmos_vsync (cmos_vsync),
        .cmos_href  (cmos_href),
        .cmos_data  (cmos_data),
        .cap_en     (cap_en),
        .dout       (dout),
        .dout_vld   (dout_vld),
        .dout_sop   (dout_sop),
        .dout_eop   (dout_eop),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic vs();
        cmos_vsync = 1'b1;
        repeat (2) tick();
        cmos_vsync = 1'b0;
        repeat (2) tick();
    endtask

    // Drives one line; pushes the pixels the DUT is expected to emit.
    task automatic send_line(input int nbytes, input bit cap, input int row, input bit fixed);
        logic [7:0] hi, b;
        exp_t       e;
        hi = '0;
        cmos_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            b = 8'($urandom_range(0, 255));
            if (fixed && i == 0) b = 8'hF8;
            if (fixed && i == 1) b = 8'h1F;
            cmos_data = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (cap && row < V && i / 2 < H) begin
                e.word = {hi, b};
                e.sop  = (row == 0) && (i / 2 == 0);
                e.eop  = (row == V - 1) && (i / 2 == H - 1);
                e.cyc  = cyc + 2;
                sb.push_back(e);
            end
            tick();
        end
        cmos_href = 1'b0;
        cmos_data = '0;
        repeat (4) tick();
    endtask

    task automatic frame_lines(input bit cap, input int nlines);
        for (int r = 0; r < nlines; r++) send_line(2 * H, cap, r, 1'b0);
    endtask

    task automatic check_frame(input string tag, input int ev, input int es, input int ee, input int er);
        check({tag, "_vld"}, vld_cnt - vld_snap, ev);
        check({tag, "_sop"}, sop_cnt - sop_snap, es);
        check({tag, "_eop"}, eop_cnt - eop_snap, ee);
        check({tag, "_err"}, err_cnt - err_snap, er);
        vld_snap = vld_cnt;
        sop_snap = sop_cnt;
        eop_snap = eop_cnt;
        err_snap = err_cnt;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_vld"}, dout_vld, 0);
        check({tag, "_sop"}, dout_sop, 0);
        check({tag, "_eop"}, dout_eop, 0);
        check({tag, "_err"}, frame_err, 0);
    endtask

    // Output monitor: every pixel is matched against the scoreboard, including its arrival cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_err === 1'b1) err_cnt++;
            if (dout_vld === 1'b1) begin
                vld_cnt++;
                if (dout_sop === 1'b1) begin
                    sop_cnt++;
                    sop_word = dout;
                end
                if (dout_eop === 1'b1) eop_cnt++;
                check("sb_has_entry", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("px_dout", dout, e.word);
                    check("px_sop", dout_sop, e.sop);
                    check("px_eop", dout_eop, e.eop);
                    check("px_cycle", cyc, e.cyc);
                    $display("pixel cyc=%0d dout=%h sop=%b eop=%b", cyc, dout, dout_sop, dout_eop);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hi, b;
        exp_t       e;
        hi = '0;
        rst = 1'b1;
        cmos_vsync = 1'b0;
        cmos_href = 1'b0;
        cmos_data = '0;
        cap_en = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Two settling frames, then the first captured frame.
        vs();  frame_lines(1'b0, V);
        vs();  check_frame("f1", 0, 0, 0, 0);
        frame_lines(1'b0, V);
        vs();  check_frame("f2", 0, 0, 0, 0);
        send_line(2 * H, 1'b1, 0, 1'b1);
        send_line(2 * H, 1'b1, 1, 1'b0);
        vs();  check_frame("f3", 8, 1, 1, 0);
        check("rgb_r", rgb565_r(sop_word), 5'h1F);
        check("rgb_g", rgb565_g(sop_word), 6'h00);
        check("rgb_b", rgb565_b(sop_word), 5'h1F);

        // Odd trailing byte on line 0.
        send_line(2 * H + 1, 1'b1, 0, 1'b0);
        send_line(2 * H, 1'b1, 1, 1'b0);
        vs();  check_frame("f4_odd", 8, 1, 1, 1);

        // Short frame: only one line before the next vsync.
        send_line(2 * H, 1'b1, 0, 1'b0);
        vs();  check_frame("f5_short", 4, 1, 0, 1);

        // cap_en dropped mid-frame: this frame still completes.
        send_line(2 * H, 1'b1, 0, 1'b0);
        cap_en = 1'b0;
        send_line(2 * H, 1'b1, 1, 1'b0);
        vs();  check_frame("f6_capoff", 8, 1, 1, 0);
        send_line(2 * H, 1'b0, 0, 1'b0);
        cap_en = 1'b1;
        send_line(2 * H, 1'b0, 1, 1'b0);
        vs();  check_frame("f7_idle", 0, 0, 0, 0);

        // Excess line after eop.
        frame_lines(1'b1, V + 1);
        vs();  check_frame("f8_excess", 8, 1, 1, 1);

        // Reset in the middle of a line; the third pixel is in flight and lost.
        cmos_href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            cmos_data = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (i < 4) begin
                e.word = {hi, b};
                e.sop  = (i == 1);
                e.eop  = 1'b0;
                e.cyc  = cyc + 2;
                sb.push_back(e);
            end
            tick();
        end
        rst = 1'b1;
        tick();
        check_idle("midrst");
        rst = 1'b0;
        cmos_href = 1'b0;
        cmos_data = '0;
        tick();
        check_frame("f9_partial", 2, 1, 0, 0);

        vs();  frame_lines(1'b1 & 1'b0, V);
        vs();  check_frame("reskip1", 0, 0, 0, 0);
        frame_lines(1'b0, V);
        vs();  check_frame("reskip2", 0, 0, 0, 0);
        frame_lines(1'b1, V);
        vs();  check_frame("recap", 8, 1, 1, 0);

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmos_capture.md
Name: cmos_capture

Overview:
Upstream stage of the SDRAM frame-buffer controller. Samples the camera DVP bus (vsync, href, 8-bit data) in the pixel-clock domain and packs byte pairs into RGB565 words. Emits a qualified 16-bit pixel stream with start-of-frame and end-of-frame markers on the controller's din/din_vld/din_sop/din_eop inputs. Discards the camera's settling frames and enforces exact frame geometry.

Parameters:
H_PIXELS, 640, pixels per line (2 bytes each)
V_LINES, 480, lines per frame
SKIP_FRAMES, 10, frames discarded after reset before capture begins

Ports:
clk  in  1  camera pixel clock; the block's only clock
rst  in  1  synchronous, active-high reset
cmos_vsync  in  1  frame sync, active high; rising edge = frame boundary
cmos_href  in  1  line valid, active high
cmos_data  in  8  pixel byte; first byte of a pair = RGB565[15:8]
cap_en  in  1  capture enable; sampled only at frame boundaries
dout  out  16  packed RGB565 pixel
dout_vld  out  1  dout valid, one-cycle qualifier per pixel
dout_sop  out  1  high with the first pixel of a frame (row 0, col 0)
dout_eop  out  1  high with the last pixel of a frame (row V_LINES-1, col H_PIXELS-1)
frame_err  out  1  one-cycle pulse: frame ended short or carried excess data

Behaviour:
- One clock: clk. Reset is synchronous and active-high (rst). All state updates on the clk rising edge.
- Reset values: dout=0, dout_vld=0, dout_sop=0, dout_eop=0, frame_err=0, FSM=S_SKIP, all counters 0.
- Input stage: vsync, href and data are registered once. vs_rise is derived from the registered vsync and its one-cycle-delayed copy.
- FSM:
  - S_SKIP: count vs_rise. After SKIP_FRAMES rises -> S_WAIT. With SKIP_FRAMES=0, go straight to S_WAIT.
  - S_WAIT: on vs_rise, if cap_en=1 -> S_CAP, else stay. Clear row, col and byte phase.
  - S_CAP: pack and emit. On vs_rise: if the frame was complete (eop emitted), no error. If eop was not emitted, pulse frame_err. Then re-evaluate cap_en: 1 -> stay in S_CAP with counters cleared, 0 -> S_WAIT.
- cap_en deassertion mid-frame has no effect until the next vs_rise. Frames are never partial because of cap_en.
- Packing in S_CAP, while registered href=1:
  - Byte phase toggles each cycle. Phase 0 latches the high byte.
  - Phase 1 forms dout={hi, data} and asserts dout_vld for one cycle.
- Latency: the low byte present at the pins in cycle k produces dout_vld=1 in cycle k+2.
- Line end: href falling resets byte phase to 0. An odd trailing byte is dropped and frame_err pulses.
  - If col≠0 at href fall, row increments and col clears.
- Geometry:
  - col counts 0..H_PIXELS-1. Pixels with col≥H_PIXELS are dropped and frame_err pulses once for that line.
  - row counts 0..V_LINES-1. All data after the eop pixel is dropped and frame_err pulses once.
- dout_sop=dout_vld & row==0 & col==0. dout_eop=dout_vld & row==V_LINES-1 & col==H_PIXELS-1. For a 1×1 frame, sop and eop assert in the same cycle.
- dout holds its last value when dout_vld=0.
- Simultaneous events: vs_rise together with registered href=1 is a frame boundary. The byte in that cycle is discarded.
- Reset mid-frame: immediate return to S_SKIP. The skip count restarts from 0 and any in-flight pixel is lost (no vld, no eop).
- Counter widths: $clog2(H_PIXELS+1), $clog2(V_LINES+1), $clog2(SKIP_FRAMES+1), minimum 1 bit each.

Decomposition:
- Shared package cmos_pkg holds:
  - FSM state encoding: S_SKIP, S_WAIT, S_CAP.
  - Default geometry constants: 640, 480, 10.
  - RGB565 field slices: R[15:11], G[10:5], B[4:0].
- One natural sub-module, cmos_byte_pack: byte-phase register plus 16-bit assembly, producing word and word_vld.
- The top level owns edge detection, the FSM and row/col counters.

Test Plan:
- Reset, SKIP_FRAMES=2, 4×2 frames -> frames 1–2 produce no dout_vld. Frame 3 yields exactly 8 vld pulses, sop on the first, eop on the 8th, frame_err=0.
- Bytes 0xF8,0x1F at pins cycles k,k+1 -> dout=16'hF81F with dout_vld=1 at cycle k+2.
- Line with 9 bytes (H_PIXELS=4) -> 4 pixels emitted, 9th byte dropped, frame_err one pulse, next line starts at col 0.
- vsync rises after 1 of 2 lines -> no eop, frame_err pulse on that vs_rise, next frame sop at row 0 col 0.
- cap_en dropped mid-frame 3 -> frame 3 completes with eop. Frame 4 is not captured. cap_en restored -> capture resumes on the following vs_rise.
- rst asserted mid-line in S_CAP -> outputs 0 the next cycle; re-skips SKIP_FRAMES frames before the next sop.
